// File: rtl/rs_pkg.sv
// Shared types and constants for the Tomasulo reservation station.
// RS_OLDEST_FIRST_EN adds a per-entry age field used for oldest-first issue.
package rs_pkg;

  localparam int unsigned RS_DEPTH = 4;
  localparam int unsigned RS_XLEN  = 32;
  localparam int unsigned RS_ROB_W = 3;
  localparam int unsigned RS_CNT_W = 3;
`ifdef RS_OLDEST_FIRST_EN
  localparam int unsigned RS_AGE_W = 4;
`endif

  localparam logic [6:0] OP_ALU  = 7'b0110011;
  localparam logic [6:0] OP_MUL  = 7'b1100011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;

  typedef enum logic [1:0] {CLS_ADD, CLS_MUL, CLS_LD, CLS_NONE} rs_class_e;

  typedef struct packed {
    logic                busy;
    logic [6:0]          fun7;
    logic [2:0]          fun3;
    logic [11:0]         imm;
    logic [RS_ROB_W-1:0] rob;
    logic [RS_XLEN-1:0]  vj;
    logic [RS_XLEN-1:0]  vk;
    logic [RS_ROB_W-1:0] qj;
    logic [RS_ROB_W-1:0] qk;
    logic                rj;
    logic                rk;
`ifdef RS_OLDEST_FIRST_EN
    logic [RS_AGE_W-1:0] age;
`endif
  } rs_entry_t;

  function automatic rs_class_e rs_decode(input logic [6:0] op);
    case (op)
      OP_ALU:  return CLS_ADD;
      OP_MUL:  return CLS_MUL;
      OP_LOAD: return CLS_LD;
      default: return CLS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rs_group.sv
// One class's reservation entries: dispatch capture, CDB snoop, issue select, count.
// With RS_OLDEST_FIRST_EN the oldest ready entry wins, ties to the lowest index.
module rs_group
  import rs_pkg::*;
#(
  parameter int unsigned DEPTH   = RS_DEPTH,
  parameter int unsigned XLEN    = RS_XLEN,
  parameter int unsigned ROB_W   = RS_ROB_W,
  parameter bit          IS_LOAD = 1'b0
) (
  input  logic                clk1,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                dis_valid,
  input  logic [6:0]          dis_fun7,
  input  logic [2:0]          dis_fun3,
  input  logic [11:0]         dis_imm,
  input  logic [ROB_W-1:0]    dis_rob,
  input  logic                src1_rdy,
  input  logic [ROB_W-1:0]    src1_tag,
  input  logic [XLEN-1:0]     src1_val,
  input  logic                src2_rdy,
  input  logic [ROB_W-1:0]    src2_tag,
  input  logic [XLEN-1:0]     src2_val,
  input  logic                cdb_valid,
  input  logic [ROB_W-1:0]    cdb_tag,
  input  logic [XLEN-1:0]     cdb_val,
  output logic                iss_valid,
  input  logic                iss_ready,
  output logic [6:0]          iss_fun7,
  output logic [2:0]          iss_fun3,
  output logic [XLEN-1:0]     iss_vj,
  output logic [XLEN-1:0]     iss_vk,
  output logic [11:0]         iss_imm,
  output logic [ROB_W-1:0]    iss_rob,
  output logic [RS_CNT_W-1:0] cnt
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rs_entry_t             ent_q [DEPTH];
  rs_entry_t             ent_d [DEPTH];
  rs_entry_t             new_ent;
  logic [RS_CNT_W-1:0]   cnt_q, cnt_d;
  logic                  accept, free_found, sel_found;
  logic [IDX_W-1:0]      free_idx, sel_idx;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!ent_q[i].busy && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (ent_q[i].busy && ent_q[i].rj && ent_q[i].rk) begin
`ifdef RS_OLDEST_FIRST_EN
        if (!sel_found || ent_q[i].age > ent_q[sel_idx].age) begin
`else
        if (!sel_found) begin
`endif
          sel_found = 1'b1;
          sel_idx   = IDX_W'(i);
        end
      end
    end
  end

  assign accept = dis_valid && (32'(cnt_q) < DEPTH);

  // Dispatch-time operand capture, including the same-cycle CDB bypass.
  always_comb begin
    new_ent      = '0;
    new_ent.busy = 1'b1;
    new_ent.fun7 = dis_fun7;
    new_ent.fun3 = dis_fun3;
    new_ent.imm  = dis_imm;
    new_ent.rob  = dis_rob;
    if (src1_rdy) begin
      new_ent.vj = src1_val;
      new_ent.rj = 1'b1;
    end else if (cdb_valid && cdb_tag == src1_tag) begin
      new_ent.vj = cdb_val;
      new_ent.rj = 1'b1;
    end else begin
      new_ent.qj = src1_tag;
    end
    if (IS_LOAD) begin
      new_ent.rk = 1'b1;
    end else if (src2_rdy) begin
      new_ent.vk = src2_val;
      new_ent.rk = 1'b1;
    end else if (cdb_valid && cdb_tag == src2_tag) begin
      new_ent.vk = cdb_val;
      new_ent.rk = 1'b1;
    end else begin
      new_ent.qk = src2_tag;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].busy && cdb_valid) begin
        if (!ent_q[i].rj && ent_q[i].qj == cdb_tag) begin
          ent_d[i].vj = cdb_val;
          ent_d[i].rj = 1'b1;
        end
        if (!ent_q[i].rk && ent_q[i].qk == cdb_tag) begin
          ent_d[i].vk = cdb_val;
          ent_d[i].rk = 1'b1;
        end
      end
`ifdef RS_OLDEST_FIRST_EN
      if (ent_q[i].busy && ent_q[i].age != '1)
        ent_d[i].age = ent_q[i].age + 1'b1;
`endif
    end
    if (sel_found && iss_ready)
      ent_d[sel_idx].busy = 1'b0;
    if (accept && free_found)
      ent_d[free_idx] = new_ent;
    if (flush)
      for (int unsigned i = 0; i < DEPTH; i++) ent_d[i].busy = 1'b0;
    cnt_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      cnt_d = cnt_d + RS_CNT_W'(ent_d[i].busy);
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      cnt_q <= cnt_d;
    end
  end

  assign cnt       = cnt_q;
  assign iss_valid = sel_found;
  assign iss_fun7  = sel_found ? ent_q[sel_idx].fun7 : '0;
  assign iss_fun3  = sel_found ? ent_q[sel_idx].fun3 : '0;
  assign iss_vj    = sel_found ? ent_q[sel_idx].vj   : '0;
  assign iss_vk    = sel_found ? ent_q[sel_idx].vk   : '0;
  assign iss_imm   = sel_found ? ent_q[sel_idx].imm  : '0;
  assign iss_rob   = sel_found ? ent_q[sel_idx].rob  : '0;

endmodule

// File: rtl/reservation_station.sv
// Reservation station top: opcode decode and dispatch steering into ADD/MUL/LOAD groups.
// Build option RS_OLDEST_FIRST_EN selects oldest-first issue inside each group.
module reservation_station
  import rs_pkg::*;
#(
  parameter int unsigned DEPTH = RS_DEPTH,
  parameter int unsigned XLEN  = RS_XLEN,
  parameter int unsigned ROB_W = RS_ROB_W
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             dis_valid,
  input  logic [6:0]       dis_opcode,
  input  logic [6:0]       dis_fun7,
  input  logic [2:0]       dis_fun3,
  input  logic [11:0]      dis_imm,
  input  logic [ROB_W-1:0] dis_rob,
  input  logic             src1_rdy,
  input  logic             src2_rdy,
  input  logic [ROB_W-1:0] src1_tag,
  input  logic [ROB_W-1:0] src2_tag,
  input  logic [XLEN-1:0]  src1_val,
  input  logic [XLEN-1:0]  src2_val,
  input  logic             cdb_valid,
  input  logic [ROB_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_val,
  output logic             add_iss_valid,
  input  logic             add_iss_ready,
  output logic [6:0]       add_iss_fun7,
  output logic [2:0]       add_iss_fun3,
  output logic [XLEN-1:0]  add_iss_vj,
  output logic [XLEN-1:0]  add_iss_vk,
  output logic [11:0]      add_iss_imm,
  output logic [ROB_W-1:0] add_iss_rob,
  output logic             mul_iss_valid,
  input  logic             mul_iss_ready,
  output logic [6:0]       mul_iss_fun7,
  output logic [2:0]       mul_iss_fun3,
  output logic [XLEN-1:0]  mul_iss_vj,
  output logic [XLEN-1:0]  mul_iss_vk,
  output logic [11:0]      mul_iss_imm,
  output logic [ROB_W-1:0] mul_iss_rob,
  output logic             ld_iss_valid,
  input  logic             ld_iss_ready,
  output logic [6:0]       ld_iss_fun7,
  output logic [2:0]       ld_iss_fun3,
  output logic [XLEN-1:0]  ld_iss_vj,
  output logic [XLEN-1:0]  ld_iss_vk,
  output logic [11:0]      ld_iss_imm,
  output logic [ROB_W-1:0] ld_iss_rob,
  output logic [2:0]       add_cnt,
  output logic [2:0]       mul_cnt,
  output logic [2:0]       ld_cnt
);

  rs_class_e cls;

  assign cls = rs_decode(dis_opcode);

  rs_group #(.DEPTH(DEPTH), .XLEN(XLEN), .ROB_W(ROB_W), .IS_LOAD(1'b0)) u_add (
    .clk1(clk1), .rst_n(rst_n), .flush(flush),
    .dis_valid(dis_valid && cls == CLS_ADD),
    .dis_fun7(dis_fun7), .dis_fun3(dis_fun3), .dis_imm(dis_imm), .dis_rob(dis_rob),
    .src1_rdy(src1_rdy), .src1_tag(src1_tag), .src1_val(src1_val),
    .src2_rdy(src2_rdy), .src2_tag(src2_tag), .src2_val(src2_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .iss_valid(add_iss_valid), .iss_ready(add_iss_ready),
    .iss_fun7(add_iss_fun7), .iss_fun3(add_iss_fun3),
    .iss_vj(add_iss_vj), .iss_vk(add_iss_vk),
    .iss_imm(add_iss_imm), .iss_rob(add_iss_rob), .cnt(add_cnt)
  );

  rs_group #(.DEPTH(DEPTH), .XLEN(XLEN), .ROB_W(ROB_W), .IS_LOAD(1'b0)) u_mul (
    .clk1(clk1), .rst_n(rst_n), .flush(flush),
    .dis_valid(dis_valid && cls == CLS_MUL),
    .dis_fun7(dis_fun7), .dis_fun3(dis_fun3), .dis_imm(dis_imm), .dis_rob(dis_rob),
    .src1_rdy(src1_rdy), .src1_tag(src1_tag), .src1_val(src1_val),
    .src2_rdy(src2_rdy), .src2_tag(src2_tag), .src2_val(src2_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .iss_valid(mul_iss_valid), .iss_ready(mul_iss_ready),
    .iss_fun7(mul_iss_fun7), .iss_fun3(mul_iss_fun3),
    .iss_vj(mul_iss_vj), .iss_vk(mul_iss_vk),
    .iss_imm(mul_iss_imm), .iss_rob(mul_iss_rob), .cnt(mul_cnt)
  );

  rs_group #(.DEPTH(DEPTH), .XLEN(XLEN), .ROB_W(ROB_W), .IS_LOAD(1'b1)) u_ld (
    .clk1(clk1), .rst_n(rst_n), .flush(flush),
    .dis_valid(dis_valid && cls == CLS_LD),
    .dis_fun7(dis_fun7), .dis_fun3(dis_fun3), .dis_imm(dis_imm), .dis_rob(dis_rob),
    .src1_rdy(src1_rdy), .src1_tag(src1_tag), .src1_val(src1_val),
    .src2_rdy(src2_rdy), .src2_tag(src2_tag), .src2_val(src2_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .iss_valid(ld_iss_valid), .iss_ready(ld_iss_ready),
    .iss_fun7(ld_iss_fun7), .iss_fun3(ld_iss_fun3),
    .iss_vj(ld_iss_vj), .iss_vk(ld_iss_vk),
    .iss_imm(ld_iss_imm), .iss_rob(ld_iss_rob), .cnt(ld_cnt)
  );

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station with a per-cycle behavioural model check.
module tb_reservation_station;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        dis_valid = 1'b0;
  logic [6:0]  dis_opcode = '0, dis_fun7 = '0;
  logic [2:0]  dis_fun3 = '0, dis_rob = '0;
  logic [11:0] dis_imm = '0;
  logic        src1_rdy = 1'b0, src2_rdy = 1'b0;
  logic [2:0]  src1_tag = '0, src2_tag = '0;
  logic [31:0] src1_val = '0, src2_val = '0;
  logic        cdb_valid = 1'b0;
  logic [2:0]  cdb_tag = '0;
  logic [31:0] cdb_val = '0;
  logic        add_iss_ready = 1'b0, mul_iss_ready = 1'b0, ld_iss_ready = 1'b0;

  logic        add_iss_valid, mul_iss_valid, ld_iss_valid;
  logic [6:0]  add_iss_fun7, mul_iss_fun7, ld_iss_fun7;
  logic [2:0]  add_iss_fun3, mul_iss_fun3, ld_iss_fun3;
  logic [31:0] add_iss_vj, mul_iss_vj, ld_iss_vj;
  logic [31:0] add_iss_vk, mul_iss_vk, ld_iss_vk;
  logic [11:0] add_iss_imm, mul_iss_imm, ld_iss_imm;
  logic [2:0]  add_iss_rob, mul_iss_rob, ld_iss_rob;
  logic [2:0]  add_cnt, mul_cnt, ld_cnt;

  int n_chk = 0;
  int n_fail = 0;

  reservation_station #(.DEPTH(4), .XLEN(32), .ROB_W(3)) dut (
    .clk1(clk1), .rst_n(rst_n), .flush(flush),
    .dis_valid(dis_valid), .dis_opcode(dis_opcode), .dis_fun7(dis_fun7),
    .dis_fun3(dis_fun3), .dis_imm(dis_imm), .dis_rob(dis_rob),
    .src1_rdy(src1_rdy), .src2_rdy(src2_rdy), .src1_tag(src1_tag), .src2_tag(src2_tag),
    .src1_val(src1_val), .src2_val(src2_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .add_iss_valid(add_iss_valid), .add_iss_ready(add_iss_ready),
    .add_iss_fun7(add_iss_fun7), .add_iss_fun3(add_iss_fun3),
    .add_iss_vj(add_iss_vj), .add_iss_vk(add_iss_vk),
    .add_iss_imm(add_iss_imm), .add_iss_rob(add_iss_rob),
    .mul_iss_valid(mul_iss_valid), .mul_iss_ready(mul_iss_ready),
    .mul_iss_fun7(mul_iss_fun7), .mul_iss_fun3(mul_iss_fun3),
    .mul_iss_vj(mul_iss_vj), .mul_iss_vk(mul_iss_vk),
    .mul_iss_imm(mul_iss_imm), .mul_iss_rob(mul_iss_rob),
    .ld_iss_valid(ld_iss_valid), .ld_iss_ready(ld_iss_ready),
    .ld_iss_fun7(ld_iss_fun7), .ld_iss_fun3(ld_iss_fun3),
    .ld_iss_vj(ld_iss_vj), .ld_iss_vk(ld_iss_vk),
    .ld_iss_imm(ld_iss_imm), .ld_iss_rob(ld_iss_rob),
    .add_cnt(add_cnt), .mul_cnt(mul_cnt), .ld_cnt(ld_cnt)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: three classes of four slots ----------------
  typedef struct {
    bit        busy, rj, rk;
    bit [31:0] vj, vk;
    bit [2:0]  qj, qk, rob, fun3;
    bit [6:0]  fun7;
    bit [11:0] imm;
  } m_ent_t;

  m_ent_t m [3][4];

  function automatic int op_class(input logic [6:0] op);
    if (op == 7'b0110011) return 0;
    if (op == 7'b1100011) return 1;
    if (op == 7'b0000011) return 2;
    return 3;
  endfunction

  function automatic int m_count(input int c);
    int n = 0;
    for (int i = 0; i < 4; i++) if (m[c][i].busy) n++;
    return n;
  endfunction

  function automatic int m_pick(input int c);
    for (int i = 0; i < 4; i++)
      if (m[c][i].busy && m[c][i].rj && m[c][i].rk) return i;
    return -1;
  endfunction

  always @(posedge clk1) begin
    int pick [3];
    bit rdy [3];
    int dc, slot;
    m_ent_t e;
    if (!rst_n) begin
      for (int c = 0; c < 3; c++)
        for (int i = 0; i < 4; i++) m[c][i] = '{default: 0};
    end else begin
      rdy[0] = add_iss_ready; rdy[1] = mul_iss_ready; rdy[2] = ld_iss_ready;
      dc = dis_valid ? op_class(dis_opcode) : 3;
      slot = -1;
      if (dc < 3 && m_count(dc) < 4)
        for (int i = 3; i >= 0; i--) if (!m[dc][i].busy) slot = i;
      for (int c = 0; c < 3; c++) pick[c] = m_pick(c);
      for (int c = 0; c < 3; c++) begin
        for (int i = 0; i < 4; i++) begin
          if (m[c][i].busy && cdb_valid && !m[c][i].rj && m[c][i].qj == cdb_tag) begin
            m[c][i].vj = cdb_val; m[c][i].rj = 1;
          end
          if (m[c][i].busy && cdb_valid && !m[c][i].rk && m[c][i].qk == cdb_tag) begin
            m[c][i].vk = cdb_val; m[c][i].rk = 1;
          end
        end
        if (pick[c] >= 0 && rdy[c]) m[c][pick[c]].busy = 0;
      end
      if (slot >= 0) begin
        e = '{default: 0};
        e.busy = 1; e.fun7 = dis_fun7; e.fun3 = dis_fun3; e.imm = dis_imm; e.rob = dis_rob;
        if (src1_rdy) begin e.vj = src1_val; e.rj = 1; end
        else if (cdb_valid && cdb_tag == src1_tag) begin e.vj = cdb_val; e.rj = 1; end
        else e.qj = src1_tag;
        if (dc == 2) e.rk = 1;
        else if (src2_rdy) begin e.vk = src2_val; e.rk = 1; end
        else if (cdb_valid && cdb_tag == src2_tag) begin e.vk = cdb_val; e.rk = 1; end
        else e.qk = src2_tag;
        m[dc][slot] = e;
      end
      if (flush)
        for (int c = 0; c < 3; c++)
          for (int i = 0; i < 4; i++) m[c][i].busy = 0;
    end
  end

  task automatic chk_cls(input int c, input string nm, input logic v, input logic [6:0] f7,
                         input logic [2:0] f3, input logic [31:0] vj, input logic [31:0] vk,
                         input logic [11:0] imm, input logic [2:0] rob, input logic [2:0] cnt);
    int p;
    p = m_pick(c);
    chk({nm, "_cnt"}, 32'(cnt), m_count(c));
    chk({nm, "_valid"}, 32'(v), 32'(p >= 0));
    chk({nm, "_fun7"}, 32'(f7), (p >= 0) ? 32'(m[c][p].fun7) : 0);
    chk({nm, "_fun3"}, 32'(f3), (p >= 0) ? 32'(m[c][p].fun3) : 0);
    chk({nm, "_vj"}, vj, (p >= 0) ? m[c][p].vj : 0);
    chk({nm, "_vk"}, vk, (p >= 0) ? m[c][p].vk : 0);
    chk({nm, "_imm"}, 32'(imm), (p >= 0) ? 32'(m[c][p].imm) : 0);
    chk({nm, "_rob"}, 32'(rob), (p >= 0) ? 32'(m[c][p].rob) : 0);
  endtask

  always @(negedge clk1) begin
    if (rst_n) begin
      chk_cls(0, "add", add_iss_valid, add_iss_fun7, add_iss_fun3, add_iss_vj, add_iss_vk,
              add_iss_imm, add_iss_rob, add_cnt);
      chk_cls(1, "mul", mul_iss_valid, mul_iss_fun7, mul_iss_fun3, mul_iss_vj, mul_iss_vk,
              mul_iss_imm, mul_iss_rob, mul_cnt);
      chk_cls(2, "ld", ld_iss_valid, ld_iss_fun7, ld_iss_fun3, ld_iss_vj, ld_iss_vk,
              ld_iss_imm, ld_iss_rob, ld_cnt);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic dispatch(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                          input logic [11:0] imm, input logic [2:0] rob,
                          input logic r1, input logic [2:0] t1, input logic [31:0] v1,
                          input logic r2, input logic [2:0] t2, input logic [31:0] v2);
    dis_valid = 1'b1; dis_opcode = op; dis_fun7 = f7; dis_fun3 = f3; dis_imm = imm;
    dis_rob = rob; src1_rdy = r1; src1_tag = t1; src1_val = v1;
    src2_rdy = r2; src2_tag = t2; src2_val = v2;
    step();
    dis_valid = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_add_valid", 32'(add_iss_valid), 0);
    chk("rst_mul_valid", 32'(mul_iss_valid), 0);
    chk("rst_ld_valid", 32'(ld_iss_valid), 0);
    chk("rst_cnts", {23'b0, add_cnt, mul_cnt, ld_cnt}, 0);
    chk("rst_add_vj", add_iss_vj, 0);
    #9 rst_n = 1'b1;
    step();

    // ALU with both operands ready
    dispatch(7'b0110011, 7'h20, 3'd0, 12'h0, 3'd2, 1, 0, 32'd5, 1, 0, 32'd7);
    chk("alu_cnt", 32'(add_cnt), 1);
    chk("alu_valid", 32'(add_iss_valid), 1);
    chk("alu_vj", add_iss_vj, 5);
    chk("alu_vk", add_iss_vk, 7);
    chk("alu_rob", 32'(add_iss_rob), 2);
    chk("alu_fun7", 32'(add_iss_fun7), 32'h20);
    add_iss_ready = 1'b1;
    step();
    add_iss_ready = 1'b0;
    chk("alu_drain_cnt", 32'(add_cnt), 0);
    chk("alu_drain_valid", 32'(add_iss_valid), 0);

    // MUL waiting on tag 4, woken by the CDB
    dispatch(7'b1100011, 7'h01, 3'd0, 12'h0, 3'd5, 1, 0, 32'd3, 0, 3'd4, 32'hFFFF);
    chk("mul_cnt", 32'(mul_cnt), 1);
    chk("mul_wait_valid", 32'(mul_iss_valid), 0);
    step();
    chk("mul_still_wait", 32'(mul_iss_valid), 0);
    cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_val = 32'h10;
    step();
    cdb_valid = 1'b0;
    chk("mul_wake_valid", 32'(mul_iss_valid), 1);
    chk("mul_wake_vk", mul_iss_vk, 32'h10);
    chk("mul_wake_vj", mul_iss_vj, 3);
    mul_iss_ready = 1'b1;
    step();
    mul_iss_ready = 1'b0;
    chk("mul_drain_cnt", 32'(mul_cnt), 0);

    // LOAD fill to capacity; src2 fields must be ignored
    for (int k = 0; k < 4; k++)
      dispatch(7'b0000011, 7'h0, 3'd2, 12'(16 * k + 4), 3'(k), 1, 0, 32'(100 + k),
               1, 0, 32'hDEAD);
    chk("ld_full_cnt", 32'(ld_cnt), 4);
    chk("ld_vj", ld_iss_vj, 100);
    chk("ld_vk_zero", ld_iss_vk, 0);
    chk("ld_imm", 32'(ld_iss_imm), 32'h4);
    dispatch(7'b0000011, 7'h0, 3'd2, 12'h7FF, 3'd4, 1, 0, 32'd999, 1, 0, 32'd0);
    chk("ld_fifth_ignored", 32'(ld_cnt), 4);
    // full class with a concurrent issue still rejects the dispatch
    ld_iss_ready = 1'b1;
    dispatch(7'b0000011, 7'h0, 3'd2, 12'h7FF, 3'd6, 1, 0, 32'd888, 1, 0, 32'd0);
    ld_iss_ready = 1'b0;
    chk("ld_full_issue_cnt", 32'(ld_cnt), 3);
    chk("ld_next_sel", ld_iss_vj, 101);
    dispatch(7'b0000011, 7'h0, 3'd2, 12'h123, 3'd7, 1, 0, 32'd200, 1, 0, 32'd0);
    chk("ld_refill_cnt", 32'(ld_cnt), 4);
    chk("ld_refill_slot0", ld_iss_vj, 200);
    chk("ld_refill_rob", 32'(ld_iss_rob), 7);
    ld_iss_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    ld_iss_ready = 1'b0;
    chk("ld_drain_cnt", 32'(ld_cnt), 0);

    // same-cycle CDB bypass on src1
    cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_val = 32'h55;
    dispatch(7'b0110011, 7'h0, 3'd1, 12'h0, 3'd1, 0, 3'd3, 32'hBAD, 1, 0, 32'd1);
    cdb_valid = 1'b0;
    chk("byp_valid", 32'(add_iss_valid), 1);
    chk("byp_vj", add_iss_vj, 32'h55);
    add_iss_ready = 1'b1;
    step();
    add_iss_ready = 1'b0;

    // unknown opcode
    dispatch(7'b0010011, 7'h0, 3'd0, 12'h0, 3'd0, 1, 0, 32'd1, 1, 0, 32'd2);
    chk("unk_cnts", {23'b0, add_cnt, mul_cnt, ld_cnt}, 0);

    // all three classes issue together
    dispatch(7'b0110011, 7'h0, 3'd0, 12'h0, 3'd1, 1, 0, 32'd11, 1, 0, 32'd12);
    dispatch(7'b1100011, 7'h1, 3'd0, 12'h0, 3'd2, 1, 0, 32'd13, 1, 0, 32'd14);
    dispatch(7'b0000011, 7'h0, 3'd2, 12'h8, 3'd3, 1, 0, 32'd15, 1, 0, 32'd16);
    chk("tri_valid", {29'b0, add_iss_valid, mul_iss_valid, ld_iss_valid}, 32'h7);
    add_iss_ready = 1'b1; mul_iss_ready = 1'b1; ld_iss_ready = 1'b1;
    step();
    add_iss_ready = 1'b0; mul_iss_ready = 1'b0; ld_iss_ready = 1'b0;
    chk("tri_cnts", {23'b0, add_cnt, mul_cnt, ld_cnt}, 0);

    // flush overrides a concurrent dispatch
    for (int k = 0; k < 3; k++)
      dispatch(7'b0110011, 7'h0, 3'd0, 12'h0, 3'(k), 0, 3'd6, 32'd0, 1, 0, 32'd0);
    chk("pre_flush_cnt", 32'(add_cnt), 3);
    flush = 1'b1;
    dispatch(7'b0110011, 7'h0, 3'd0, 12'h0, 3'd5, 1, 0, 32'd1, 1, 0, 32'd1);
    flush = 1'b0;
    chk("flush_cnts", {23'b0, add_cnt, mul_cnt, ld_cnt}, 0);
    dispatch(7'b1100011, 7'h1, 3'd0, 12'h0, 3'd6, 1, 0, 32'd2, 1, 0, 32'd3);
    chk("post_flush_mul_cnt", 32'(mul_cnt), 1);
    mul_iss_ready = 1'b1;
    step();
    mul_iss_ready = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
